// File: rtl/lsu_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_hs_if
// Brief    : Request/response handshake bundle between core and lsu_hs.
// Revision : 1.0
// ============================================================================
interface lsu_hs_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [2:0]  i_req_funct3;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_err;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_funct3, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/lsu_hs.sv
`default_nettype none
// ============================================================================
// Module   : lsu_hs
// Brief    : Handshaked RV32I load/store unit with byte-enabled sync-read RAM.
//            Optional macro LSU_PERF_CNT_EN adds ld/st/err handshake counters.
// Revision : 1.0
// ============================================================================
module lsu_hs #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH_WORDS = 256
) (
    input  wire logic   i_clk,
    input  wire logic   i_rst,
    lsu_hs_if.slave     s_bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_ld,
    output logic [31:0] o_perf_st,
    output logic [31:0] o_perf_err
`endif
);

    localparam int          c_AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_ADDR_HI = c_ADDR_LO + 33'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LD_WAIT = 2'd1,
        S_RESP    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_lane;
    logic [2:0]  r_f3;
    logic        r_we;
    logic [31:0] r_rdword;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_err;
    logic [31:0] w_rdata_nxt;
    logic [1:0]  w_err_nxt;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_illegal;
    logic            w_misal;
    logic            w_fault;
    logic [1:0]      w_err_code;
    logic [32:0]     w_addr33;
    logic [c_AW-1:0] w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_wdat;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [7:0]      w_ld_byte;
    logic [15:0]     w_ld_half;
    logic [31:0]     w_ld_fmt;

    // Ready is masked during reset so nothing can be accepted (or written) while held.
    assign s_bus.o_req_ready = (r_state == S_IDLE) && i_rst;
    assign s_bus.o_rsp_valid = (r_state == S_RESP);
    assign s_bus.o_rsp_rdata = r_rsp_rdata;
    assign s_bus.o_rsp_err   = r_rsp_err;

    assign w_accept = s_bus.i_req_valid && s_bus.o_req_ready;
    assign w_addr33 = {1'b0, s_bus.i_req_addr};

    always_comb begin
        w_illegal = 1'b0;
        if (s_bus.i_req_we)
            w_illegal = (s_bus.i_req_funct3 != 3'b000) && (s_bus.i_req_funct3 != 3'b001)
                     && (s_bus.i_req_funct3 != 3'b010);
        else
            w_illegal = (s_bus.i_req_funct3 == 3'b011) || (s_bus.i_req_funct3 == 3'b110)
                     || (s_bus.i_req_funct3 == 3'b111);
        w_misal = ((s_bus.i_req_funct3[1:0] == 2'b01) && s_bus.i_req_addr[0])
               || ((s_bus.i_req_funct3[1:0] == 2'b10) && (s_bus.i_req_addr[1:0] != 2'b00));
        w_fault = !((w_addr33 >= c_ADDR_LO) && (w_addr33 < c_ADDR_HI));
        if (w_illegal)    w_err_code = 2'b11;
        else if (w_misal) w_err_code = 2'b01;
        else if (w_fault) w_err_code = 2'b10;
        else              w_err_code = 2'b00;
    end

    // BASE_ADDR is word aligned, so the word index only needs the low address bits.
    assign w_idx   = s_bus.i_req_addr[c_AW+1:2] - BASE_ADDR[c_AW+1:2];
    assign w_wr_en = w_accept && s_bus.i_req_we && (w_err_code == 2'b00);
    assign w_rd_en = w_accept && !s_bus.i_req_we && (w_err_code == 2'b00);

    always_comb begin
        case (s_bus.i_req_funct3[1:0])
            2'b00: begin
                w_be   = 4'b0001 << s_bus.i_req_addr[1:0];
                w_wdat = {4{s_bus.i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = s_bus.i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{s_bus.i_req_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wdat = s_bus.i_req_wdata;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_wr_en && w_be[b])
                r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
        end
        if (w_rd_en)
            r_rdword <= r_mem[w_idx];
    end

    assign w_ld_byte = r_rdword[8*r_lane +: 8];
    assign w_ld_half = r_lane[1] ? r_rdword[31:16] : r_rdword[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_ld_fmt = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_fmt = {24'h0, w_ld_byte};
            3'b001:  w_ld_fmt = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_fmt = {16'h0, w_ld_half};
            default: w_ld_fmt = r_rdword;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 2'b00;
            r_lane      <= 2'b00;
            r_f3        <= 3'b000;
            r_we        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_rdata <= w_rdata_nxt;
            r_rsp_err   <= w_err_nxt;
            if (w_accept) begin
                r_lane <= s_bus.i_req_addr[1:0];
                r_f3   <= s_bus.i_req_funct3;
                r_we   <= s_bus.i_req_we;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rdata_nxt = r_rsp_rdata;
        w_err_nxt   = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_rdata_nxt = 32'h0;
                    w_err_nxt   = w_err_code;
                    if ((w_err_code != 2'b00) || s_bus.i_req_we)
                        w_state_nxt = S_RESP;
                    else
                        w_state_nxt = S_LD_WAIT;
                end
            end
            S_LD_WAIT: begin
                w_rdata_nxt = w_ld_fmt;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (s_bus.i_rsp_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef LSU_PERF_CNT_EN
    logic w_rsp_hs;
    assign w_rsp_hs = (r_state == S_RESP) && s_bus.i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_perf_ld  <= 32'h0;
            o_perf_st  <= 32'h0;
            o_perf_err <= 32'h0;
        end else if (w_rsp_hs) begin
            if (r_rsp_err != 2'b00) o_perf_err <= o_perf_err + 32'd1;
            else if (r_we)          o_perf_st  <= o_perf_st + 32'd1;
            else                    o_perf_ld  <= o_perf_ld + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/lsu_hs.md
Name: lsu_hs

Overview:
Parametrised, handshaked successor to the single-cycle load/store unit. It accepts one RV32I load/store request at a time over a valid/ready interface and owns a synchronous-read, byte-enabled data memory of DEPTH_WORDS words at BASE_ADDR. It formats load data (sign/zero extension) and returns a registered response with an error code. It sits between the core's memory stage and data RAM, so multi-cycle or stalling cores can use it.

Parameters:
BASE_ADDR, 32'h1000_0000, byte address of memory word 0.
DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 4 (256 = 1 KiB).

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst  input  1  asynchronous, active-low reset.
i_req_valid  input  1  request present.
o_req_ready  output  1  request can be accepted; high only in IDLE.
i_req_we  input  1  1 = store, 0 = load.
i_req_addr  input  32  byte address.
i_req_wdata  input  32  store data; low byte/half used for SB/SH.
i_req_funct3  input  3  RV32I funct3; loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
o_rsp_valid  output  1  response present; held until accepted.
i_rsp_ready  input  1  consumer accepts response.
o_rsp_rdata  output  32  formatted load data; 0 for stores and errors.
o_rsp_err  output  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0. o_req_ready=1 once reset is released. Memory contents are not cleared. Reset mid-operation abandons the request: no response is produced, and a store already written stays written.
- FSM states are IDLE, LD_WAIT and RESP. A request is accepted when i_req_valid && o_req_ready; all request fields are sampled at that edge.
- Error check at accept, with priority illegal > misaligned > fault:
  - Illegal: funct3 011/110/111 for loads; any funct3 other than 000/001/010 for stores.
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Fault: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). The compare is done in 33 bits, so there is no wrap-around.
- On error: no memory read or write. Go to RESP; o_rsp_valid=1 the next cycle with the error code and rdata=0.
- Store, ok: the byte-enabled write happens at the accept edge.
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes {1,0} or {3,2} (by addr[1]) get wdata[15:0].
  - SW: all 4 lanes.
  - Other bytes are untouched (true byte enables, no read-modify-write).
  - Go to RESP; response 1 cycle after accept, err=00, rdata=0.
- Load, ok: the read of word index (addr-BASE_ADDR)>>2 is issued at the accept edge; go to LD_WAIT.
  - In LD_WAIT the RAM output is formatted using the latched addr[1:0] and funct3, then registered into o_rsp_rdata; go to RESP.
  - Response is valid 2 cycles after accept.
  - Sign extension for LB/LH, zero extension for LBU/LHU.
- RESP: outputs are held stable while o_rsp_valid && !i_rsp_ready. When i_rsp_ready=1, go to IDLE with o_rsp_valid=0 next cycle.
- Throughput: at most one request in flight. New accept is possible the cycle after the response handshake.
- A load to the same word one cycle after a store response returns the new data.

Optional Feature:
Macro LSU_PERF_CNT_EN.
- Defined: adds outputs o_perf_ld, o_perf_st and o_perf_err, each 32 bits.
  - Each counts completed response handshakes (o_rsp_valid && i_rsp_ready) of ok loads, ok stores and errored requests respectively.
  - Counters reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- SW 0xDEADBEEF to 0x1000_0010, then LW 0x1000_0010 -> store rsp 1 cycle after accept, err=00; load rsp 2 cycles after accept, rdata=0xDEADBEEF.
- SB 0x80 to 0x1000_0013, then LB and LBU at 0x1000_0013 -> 0xFFFF_FF80 and 0x0000_0080; LW at 0x1000_0010 -> 0x80ADBEEF.
- LH at 0x1000_0011 -> err=01, rdata=0, memory unchanged. LW at 0x1000_0400 or 0x0FFF_FFFC -> err=10. Load funct3=011 at a misaligned address -> err=11 (priority).
- Hold i_rsp_ready=0 for 5 cycles after an LW -> o_rsp_valid, rdata and err stable, o_req_ready=0. Raise ready -> IDLE next cycle, new request accepted.
- Assert i_rst=0 while in LD_WAIT -> o_rsp_valid=0 immediately (async), no response after release, earlier stored data still readable.
- With LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned -> o_perf_ld=3, o_perf_st=2, o_perf_err=1.
